// File: rtl/prio_enc_rr.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc_rr
// Purpose  : Registered N-line priority encoder with sticky pending register
//            and valid/ready grant handshake. Define PRIO_ENC_RR_ROUND_ROBIN_EN
//            for rotating priority; fixed lowest-index priority otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module prio_enc_rr #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dis,
  input  logic [N-1:0]          req,
  output logic [$clog2(N)-1:0]  y,
  output logic                  valid,
  input  logic                  ready,
  output logic [$clog2(N):0]    pend_cnt,
  output logic                  ovf
);

  localparam int W = $clog2(N);

  localparam logic [0:0]   c_idle  = 1'b0;
  localparam logic [0:0]   c_offer = 1'b1;
  localparam logic [N-1:0] c_one   = N'(1);
  localparam logic [W-1:0] c_last  = W'(N - 1);

  logic [0:0]   r_state;
  logic [N-1:0] r_pend;
  logic [W-1:0] r_y;
  logic [W:0]   r_cnt;
  logic         r_ovf;

  logic         w_accept;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_pend_next;
  logic [W:0]   w_cnt_next;
  logic [W-1:0] w_ptr;
  logic [W-1:0] w_sel;

  function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  assign w_accept    = (r_state == c_offer) && ready;
  assign w_clr       = w_accept ? (c_one << r_y) : '0;
  // Set wins over clear: a request on the bit being accepted keeps it pending.
  assign w_pend_next = (r_pend & ~w_clr) | req;

  always_comb begin
    w_cnt_next = '0;
    for (int i = 0; i < N; i++) begin
      w_cnt_next = w_cnt_next + (W+1)'(w_pend_next[i]);
    end
  end

  // Scan downward so the first set bit at or after the pointer wins.
  always_comb begin
    w_sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (r_pend[wrap_idx(w_ptr, k)]) w_sel = wrap_idx(w_ptr, k);
    end
  end

`ifdef PRIO_ENC_RR_ROUND_ROBIN_EN
  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (!dis && w_accept) begin
      r_ptr <= (r_y == c_last) ? '0 : r_y + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_pend  <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (dis) begin
      r_state <= c_idle;
      r_pend  <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      r_cnt  <= w_cnt_next;
      r_ovf  <= |(req & r_pend & ~w_clr);
      case (r_state)
        c_idle: begin
          if (|r_pend) begin
            r_state <= c_offer;
            r_y     <= w_sel;
          end
        end
        c_offer: begin
          if (ready) begin
            r_state <= c_idle;
            r_y     <= '0;
          end
        end
        default: begin
          r_state <= c_idle;
          r_y     <= '0;
        end
      endcase
    end
  end

  assign y        = r_y;
  assign valid    = (r_state == c_offer);
  assign pend_cnt = r_cnt;
  assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_prio_enc_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_enc_rr
// Purpose  : Directed self-checking bench for prio_enc_rr (N=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prio_enc_rr;

  logic       clk;
  logic       rst_n;
  logic       dis;
  logic [7:0] req;
  logic [2:0] y;
  logic       valid;
  logic       ready;
  logic [3:0] pend_cnt;
  logic       ovf;

  int n_checks;
  int n_fail;

  prio_enc_rr #(.N(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dis      (dis),
    .req      (req),
    .y        (y),
    .valid    (valid),
    .ready    (ready),
    .pend_cnt (pend_cnt),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs then reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dis = 1'b0; req = '0; ready = 1'b0;
    #2;
    n_checks++;
    if (valid !== 1'b0 || y !== 3'd0 || pend_cnt !== 4'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b y=%0d cnt=%0d ovf=%b, want 0/0/0/0", valid, y, pend_cnt, ovf);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (valid !== 1'b0 || pend_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_idle: valid=%b cnt=%0d, want 0/0", valid, pend_cnt);
    end
  endtask

  task automatic test_basic();
    ready = 1'b1; req = 8'hA0;
    step();
    n_checks++;
    if (valid !== 1'b0 || pend_cnt !== 4'd2) begin
      n_fail++; $display("FAIL basic_capture: valid=%b cnt=%0d, want 0/2", valid, pend_cnt);
    end
    req = '0;
    step();
    n_checks++;
    if (valid !== 1'b1 || y !== 3'd5 || pend_cnt !== 4'd2) begin
      n_fail++; $display("FAIL basic_offer5: valid=%b y=%0d cnt=%0d, want 1/5/2", valid, y, pend_cnt);
    end
    step();
    n_checks++;
    if (valid !== 1'b0 || pend_cnt !== 4'd1) begin
      n_fail++; $display("FAIL basic_bubble: valid=%b cnt=%0d, want 0/1", valid, pend_cnt);
    end
    step();
    n_checks++;
    if (valid !== 1'b1 || y !== 3'd7) begin
      n_fail++; $display("FAIL basic_offer7: valid=%b y=%0d, want 1/7", valid, y);
    end
    step();
    n_checks++;
    if (valid !== 1'b0 || y !== 3'd0 || pend_cnt !== 4'd0) begin
      n_fail++; $display("FAIL basic_empty: valid=%b y=%0d cnt=%0d, want 0/0/0", valid, y, pend_cnt);
    end
  endtask

  task automatic test_sweep();
    ready = 1'b1; req = 8'hFF;
    step();
    n_checks++;
    if (pend_cnt !== 4'd8 || valid !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL sweep_capture: cnt=%0d valid=%b ovf=%b, want 8/0/0", pend_cnt, valid, ovf);
    end
    req = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (valid !== 1'b1 || y !== 3'(i) || ovf !== 1'b0) begin
        n_fail++; $display("FAIL sweep_grant%0d: valid=%b y=%0d ovf=%b, want 1/%0d/0", i, valid, y, ovf, i);
      end
      step();
      n_checks++;
      if (valid !== 1'b0 || pend_cnt !== 4'(7 - i) || ovf !== 1'b0) begin
        n_fail++; $display("FAIL sweep_bubble%0d: valid=%b cnt=%0d ovf=%b, want 0/%0d/0", i, valid, pend_cnt, ovf, 7 - i);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] pulses;
    logic [4:0] exp_ovf;
    pulses  = 8'b0000_0101;
    exp_ovf = 5'b00100;
    ready = 1'b0; req = 8'h04;
    step();
    req = '0;
    step();
    n_checks++;
    if (valid !== 1'b1 || y !== 3'd2) begin
      n_fail++; $display("FAIL hold_offer: valid=%b y=%0d, want 1/2", valid, y);
    end
    for (int c = 0; c < 5; c++) begin
      req = {7'd0, pulses[c]};
      step();
      n_checks++;
      if (valid !== 1'b1 || y !== 3'd2 || ovf !== exp_ovf[c]) begin
        n_fail++; $display("FAIL hold_cycle%0d: valid=%b y=%0d ovf=%b, want 1/2/%b", c, valid, y, ovf, exp_ovf[c]);
      end
    end
    req = '0; ready = 1'b1;
    step();
    n_checks++;
    if (valid !== 1'b0 || pend_cnt !== 4'd1 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL hold_accept: valid=%b cnt=%0d ovf=%b, want 0/1/0", valid, pend_cnt, ovf);
    end
    step();
    n_checks++;
    if (valid !== 1'b1 || y !== 3'd0) begin
      n_fail++; $display("FAIL hold_next: valid=%b y=%0d, want 1/0", valid, y);
    end
    step();
    n_checks++;
    if (valid !== 1'b0 || pend_cnt !== 4'd0) begin
      n_fail++; $display("FAIL hold_drain: valid=%b cnt=%0d, want 0/0", valid, pend_cnt);
    end
  endtask

  task automatic test_same_cycle();
    ready = 1'b0; req = 8'h08;
    step();
    req = '0;
    step();
    n_checks++;
    if (valid !== 1'b1 || y !== 3'd3) begin
      n_fail++; $display("FAIL same_offer: valid=%b y=%0d, want 1/3", valid, y);
    end
    ready = 1'b1; req = 8'h08;
    step();
    n_checks++;
    if (valid !== 1'b0 || pend_cnt !== 4'd1 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL same_setwins: valid=%b cnt=%0d ovf=%b, want 0/1/0", valid, pend_cnt, ovf);
    end
    req = '0;
    step();
    n_checks++;
    if (valid !== 1'b1 || y !== 3'd3) begin
      n_fail++; $display("FAIL same_regrant: valid=%b y=%0d, want 1/3", valid, y);
    end
    step();
    n_checks++;
    if (valid !== 1'b0 || pend_cnt !== 4'd0) begin
      n_fail++; $display("FAIL same_drain: valid=%b cnt=%0d, want 0/0", valid, pend_cnt);
    end
  endtask

  task automatic test_disable();
    ready = 1'b0; req = 8'h0F;
    step();
    n_checks++;
    if (pend_cnt !== 4'd4) begin
      n_fail++; $display("FAIL dis_capture: cnt=%0d, want 4", pend_cnt);
    end
    req = '0;
    step();
    n_checks++;
    if (valid !== 1'b1 || y !== 3'd0) begin
      n_fail++; $display("FAIL dis_offer: valid=%b y=%0d, want 1/0", valid, y);
    end
    dis = 1'b1; req = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (valid !== 1'b0 || y !== 3'd0 || pend_cnt !== 4'd0 || ovf !== 1'b0) begin
        n_fail++; $display("FAIL dis_held%0d: valid=%b y=%0d cnt=%0d ovf=%b, want 0/0/0/0", c, valid, y, pend_cnt, ovf);
      end
    end
    dis = 1'b0; req = '0;
    step();
    n_checks++;
    if (valid !== 1'b0 || pend_cnt !== 4'd0) begin
      n_fail++; $display("FAIL dis_release: valid=%b cnt=%0d, want 0/0", valid, pend_cnt);
    end
    req = 8'h10;
    step();
    req = '0; ready = 1'b1;
    step();
    n_checks++;
    if (valid !== 1'b1 || y !== 3'd4) begin
      n_fail++; $display("FAIL dis_newgrant: valid=%b y=%0d, want 1/4", valid, y);
    end
    step();
  endtask

  task automatic test_rr();
    logic [2:0] exp_y [4];
`ifdef PRIO_ENC_RR_ROUND_ROBIN_EN
    exp_y = '{3'd0, 3'd3, 3'd0, 3'd3};
`else
    exp_y = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
    // Async reset during a live offer must drop everything immediately.
    ready = 1'b0; req = 8'h02;
    step();
    req = '0;
    step();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (valid !== 1'b0 || y !== 3'd0 || pend_cnt !== 4'd0) begin
      n_fail++; $display("FAIL rst_midoffer: valid=%b y=%0d cnt=%0d, want 0/0/0", valid, y, pend_cnt);
    end
    step();
    rst_n = 1'b1;
    step();
    ready = 1'b1; req = 8'h09;
    step();
    for (int g = 0; g < 4; g++) begin
      step();
      n_checks++;
      if (valid !== 1'b1 || y !== exp_y[g]) begin
        n_fail++; $display("FAIL rr_grant%0d: valid=%b y=%0d, want 1/%0d", g, valid, y, exp_y[g]);
      end
      step();
    end
    req = '0; ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; dis = 1'b0; req = '0; ready = 1'b0;
    test_reset();
    test_basic();
    test_sweep();
    test_hold();
    test_same_cycle();
    test_disable();
    test_rr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
